fetch_seq: RTL and testbench

//  Fetch/branch sequencer for the ONC-16 core. It sequences instruction fetch

---
 rtl/fetch_seq_if.sv | 27 ++
 rtl/fetch_seq.sv | 147 ++++++++++++++
 tb/tb_fetch_seq.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_seq_if.sv
// Handshake and PC-control bundle between fetch_seq and the instruction memory,
// datapath and program counter. master = sequencer, slave = surrounding core.
interface fetch_seq_if;
    logic       imem_req;
    logic       imem_ack;
    logic       instr_valid;
    logic       exec_done;
    logic [2:0] br_op;
    logic       br_mode;
    logic       flag_z;
    logic       flag_n;
    logic       flag_c;
    logic       halt;
    logic       pc_step;
    logic       pc_bre;
    logic       pc_imr_sel;

    modport master (
        output imem_req, instr_valid, pc_step, pc_bre, pc_imr_sel,
        input  imem_ack, exec_done, br_op, br_mode, flag_z, flag_n, flag_c, halt
    );

    modport slave (
        input  imem_req, instr_valid, pc_step, pc_bre, pc_imr_sel,
        output imem_ack, exec_done, br_op, br_mode, flag_z, flag_n, flag_c, halt
    );
endinterface

// File: rtl/fetch_seq.sv
// ONC-16 fetch/branch sequencer: fetches over req/ack, hands the word to decode,
// then issues exactly one PC strobe per instruction from the latched branch outcome.
module fetch_seq #(
    parameter int unsigned ACK_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             start,
    fetch_seq_if.master      bus,
    output logic             busy,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] br_taken_cnt
);
    localparam int unsigned TMO_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_UPDATE,
        S_HALT,
        S_FAULT
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;
    logic             exec_first;
    logic             taken_q;
    logic             mode_q;
    logic             cond;

    // Branch condition from the current flags; only captured in the exec_done cycle.
    always_comb begin
        cond = 1'b0;
        case (bus.br_op)
            3'd0:    cond = 1'b0;
            3'd1:    cond = 1'b1;
            3'd2:    cond = bus.flag_z;
            3'd3:    cond = ~bus.flag_z;
            3'd4:    cond = bus.flag_n;
            3'd5:    cond = ~bus.flag_n;
            3'd6:    cond = bus.flag_c;
            3'd7:    cond = ~bus.flag_c;
            default: cond = 1'b0;
        endcase
    end

    // tmo_cnt holds the number of completed no-ack FETCH cycles, so the
    // ACK_TIMEOUT-th one faults unless its ack arrives in that same cycle.
    assign tmo_hit = (tmo_cnt == TMO_W'(ACK_TIMEOUT - 1));

    always_ff @(posedge clock) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    next_state = S_FETCH;
                end
            end
            S_FETCH: begin
                if (bus.imem_ack) begin
                    next_state = S_EXEC;
                end else if (tmo_hit) begin
                    next_state = S_FAULT;
                end
            end
            S_EXEC: begin
                if (bus.exec_done) begin
                    next_state = bus.halt ? S_HALT : S_UPDATE;
                end
            end
            S_UPDATE: next_state = S_FETCH;
            S_HALT:   next_state = S_HALT;
            S_FAULT:  next_state = S_FAULT;
            default:  next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            tmo_cnt      <= '0;
            exec_first   <= 1'b0;
            taken_q      <= 1'b0;
            mode_q       <= 1'b0;
            br_taken_cnt <= '0;
        end else begin
            if (state != S_FETCH || bus.imem_ack) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end

            exec_first <= (next_state == S_EXEC) && (state != S_EXEC);

            if (state == S_EXEC && bus.exec_done) begin
                taken_q <= cond;
                mode_q  <= bus.br_mode;
            end

            if (state == S_UPDATE && taken_q) begin
                br_taken_cnt <= br_taken_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        bus.imem_req    = 1'b0;
        bus.instr_valid = 1'b0;
        bus.pc_step     = 1'b0;
        bus.pc_bre      = 1'b0;
        bus.pc_imr_sel  = 1'b0;
        busy            = 1'b0;
        halted          = 1'b0;
        fault           = 1'b0;
        case (state)
            S_FETCH: begin
                bus.imem_req = 1'b1;
                busy         = 1'b1;
            end
            S_EXEC: begin
                bus.instr_valid = exec_first;
                busy            = 1'b1;
            end
            S_UPDATE: begin
                bus.pc_bre     = taken_q;
                bus.pc_step    = ~taken_q;
                bus.pc_imr_sel = mode_q;
                busy           = 1'b1;
            end
            S_HALT:  halted = 1'b1;
            S_FAULT: fault  = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_fetch_seq.sv
// Scoreboard bench for fetch_seq: stimulus queues expected output events,
// a negedge monitor pops and compares each event the DUT presents.
module tb_fetch_seq;
    localparam int unsigned CNT_W = 8;
    localparam int K_VALID = 0;
    localparam int K_STEP  = 1;
    localparam int K_BRE   = 2;
    localparam int K_HALT  = 3;
    localparam int K_FAULT = 4;

    typedef struct {
        int    kind;
        logic  aux;
        string tag;
    } ev_t;

    logic             clock = 1'b0;
    logic             rst;
    logic             start;
    logic             busy;
    logic             halted;
    logic             fault;
    logic [CNT_W-1:0] br_taken_cnt;
    logic             prev_h = 1'b0;
    logic             prev_f = 1'b0;

    int  tests  = 0;
    int  failed = 0;
    ev_t exp_q[$];

    fetch_seq_if bus ();

    fetch_seq #(
        .ACK_TIMEOUT(15),
        .CNT_W      (CNT_W)
    ) dut (
        .clock       (clock),
        .rst         (rst),
        .start       (start),
        .bus         (bus),
        .busy        (busy),
        .halted      (halted),
        .fault       (fault),
        .br_taken_cnt(br_taken_cnt)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic observe(input int kind, input logic aux);
        ev_t e;
        tests++;
        if (exp_q.size() == 0) begin
            failed++;
            $display("FAIL unexpected_event: got kind %0d aux %0b, required no event", kind, aux);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.aux !== aux) begin
                failed++;
                $display("FAIL %s: got kind %0d aux %0b, required kind %0d aux %0b",
                         e.tag, kind, aux, e.kind, e.aux);
            end
        end
    endtask

    // Monitor: every strobe cycle and every entry into HALT/FAULT is one event.
    initial begin
        forever begin
            @(negedge clock);
            if (bus.instr_valid) observe(K_VALID, bus.pc_imr_sel);
            if (bus.pc_step)     observe(K_STEP, bus.pc_imr_sel);
            if (bus.pc_bre)      observe(K_BRE, bus.pc_imr_sel);
            if (halted && !prev_h) observe(K_HALT, bus.pc_step | bus.pc_bre);
            if (fault && !prev_f)  observe(K_FAULT, bus.imem_req);
            prev_h = halted;
            prev_f = fault;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input int kind, input logic aux, input string tag);
        ev_t e;
        e.kind = kind;
        e.aux  = aux;
        e.tag  = tag;
        exp_q.push_back(e);
    endtask

    function automatic logic [31:0] outs();
        return {24'd0, bus.imem_req, bus.instr_valid, bus.pc_step, bus.pc_bre,
                bus.pc_imr_sel, busy, halted, fault};
    endfunction

    // Entered with the DUT in its first FETCH cycle; leaves it in the next FETCH
    // cycle (or in HALT when h=1). Misleading values surround the sampling cycles.
    task automatic do_instr(input string tag, input logic [2:0] op, input logic mode,
                            input logic z, input logic n, input logic c, input logic h,
                            input int ack_dly, input int done_dly, input logic exp_taken);
        push(K_VALID, 1'b0, {tag, "_valid"});
        if (h)              push(K_HALT, 1'b0, {tag, "_halt"});
        else if (exp_taken) push(K_BRE, mode, {tag, "_bre"});
        else                push(K_STEP, mode, {tag, "_step"});
        bus.imem_ack  = 1'b0;
        bus.exec_done = 1'b1;
        repeat (ack_dly) cyc();
        bus.imem_ack = 1'b1;
        cyc();
        bus.imem_ack  = 1'b0;
        bus.exec_done = 1'b0;
        bus.br_op     = ~op;
        bus.br_mode   = ~mode;
        bus.flag_z    = ~z;
        bus.flag_n    = ~n;
        bus.flag_c    = ~c;
        bus.halt      = ~h;
        repeat (done_dly) cyc();
        bus.br_op     = op;
        bus.br_mode   = mode;
        bus.flag_z    = z;
        bus.flag_n    = n;
        bus.flag_c    = c;
        bus.halt      = h;
        bus.exec_done = 1'b1;
        cyc();
        bus.exec_done = 1'b0;
        bus.halt      = 1'b0;
        bus.br_op     = ~op;
        bus.br_mode   = ~mode;
        bus.flag_z    = ~z;
        bus.flag_n    = ~n;
        bus.flag_c    = ~c;
        if (!h) cyc();
    endtask

    task automatic vec(input string tag, input logic [2:0] op, input logic mode,
                       input logic z, input logic n, input logic c,
                       input int ack_dly, input int done_dly, input logic exp_taken,
                       input logic [31:0] exp_cnt);
        do_instr(tag, op, mode, z, n, c, 1'b0, ack_dly, done_dly, exp_taken);
        check({tag, "_cnt"}, 32'(br_taken_cnt), exp_cnt);
        check({tag, "_back_in_fetch"}, 32'(bus.imem_req), 32'd1);
    endtask

    initial begin
        rst           = 1'b1;
        start         = 1'b0;
        bus.imem_ack  = 1'b0;
        bus.exec_done = 1'b0;
        bus.br_op     = 3'd0;
        bus.br_mode   = 1'b0;
        bus.flag_z    = 1'b0;
        bus.flag_n    = 1'b0;
        bus.flag_c    = 1'b0;
        bus.halt      = 1'b0;

        // T1: reset, idle, start
        cyc();
        check("t1_rst_outs_1", outs(), 32'd0);
        cyc();
        check("t1_rst_outs_2", outs(), 32'd0);
        check("t1_rst_cnt", 32'(br_taken_cnt), 32'd0);
        rst = 1'b0;
        cyc();
        check("t1_idle_without_start", outs(), 32'd0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("t1_req_after_start", 32'(bus.imem_req), 32'd1);
        check("t1_busy_after_start", 32'(busy), 32'd1);

        // T2/T3: directed branch vectors (3-cycle loop when both delays are 0)
        vec("t2_never",      3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 32'd0);
        vec("t3_z_taken",    3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 32'd1);
        vec("t3_nz_nottkn",  3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 32'd1);
        vec("n_taken_wait",  3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 2, 3, 1'b1, 32'd2);
        vec("nn_nottkn",     3'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1, 0, 1'b0, 32'd2);
        vec("c_taken_abs",   3'd6, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1, 1'b1, 32'd3);
        vec("nc_taken",      3'd7, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 1'b1, 32'd4);
        vec("z_nottkn",      3'd2, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 1'b0, 32'd4);
        vec("never_abs",     3'd0, 1'b1, 1'b1, 1'b1, 1'b1, 0, 0, 1'b0, 32'd4);

        // T4: always-taken register branch, then counter wrap at 2^CNT_W
        vec("t4_always_abs", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 32'd5);
        for (int i = 0; i < 250; i++) begin
            do_instr("t4_wrap_loop", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
        end
        check("t4_cnt_max", 32'(br_taken_cnt), 32'd255);
        vec("t4_wrap",       3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 32'd0);
        vec("t4_post_wrap",  3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 32'd1);

        // T5: fetch timeout
        push(K_FAULT, 1'b0, "t5_fault");
        repeat (14) cyc();
        check("t5_still_fetch", {30'd0, bus.imem_req, fault}, 32'h2);
        cyc();
        check("t5_fault_outs", outs(), 32'h1);
        start        = 1'b1;
        bus.imem_ack = 1'b1;
        repeat (2) cyc();
        start        = 1'b0;
        bus.imem_ack = 1'b0;
        check("t5_fault_sticky", outs(), 32'h1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("t5_rst_outs", outs(), 32'd0);
        check("t5_rst_cnt", 32'(br_taken_cnt), 32'd0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        do_instr("t5_ack_15th", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 14, 0, 1'b0);
        check("t5_ack_15th_no_fault", 32'(fault), 32'd0);
        do_instr("t5_ack_14th", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 13, 0, 1'b0);
        check("t5_ack_14th_no_fault", 32'(fault), 32'd0);

        // T6: halt, ignored start, reset mid-EXEC and mid-FETCH
        vec("t6_pre_taken", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 32'd1);
        do_instr("t6_halt", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1'b1);
        check("t6_halt_outs", outs(), 32'h2);
        start         = 1'b1;
        bus.imem_ack  = 1'b1;
        bus.exec_done = 1'b1;
        repeat (3) cyc();
        start         = 1'b0;
        bus.imem_ack  = 1'b0;
        bus.exec_done = 1'b0;
        check("t6_halt_sticky", outs(), 32'h2);
        check("t6_halt_cnt", 32'(br_taken_cnt), 32'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("t6_rst_halt_outs", outs(), 32'd0);
        check("t6_rst_halt_cnt", 32'(br_taken_cnt), 32'd0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        push(K_VALID, 1'b0, "t6_exec_valid");
        bus.imem_ack = 1'b1;
        cyc();
        bus.imem_ack = 1'b0;
        check("t6_in_exec_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        bus.exec_done = 1'b1;
        bus.br_op     = 3'd1;
        cyc();
        rst           = 1'b0;
        bus.exec_done = 1'b0;
        check("t6_rst_exec_outs", outs(), 32'd0);
        repeat (2) cyc();
        check("t6_idle_after_rst", outs(), 32'd0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("t6_fetch_req", 32'(bus.imem_req), 32'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("t6_rst_fetch_req", outs(), 32'd0);

        repeat (3) cyc();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
